alu_issue_ctrl: RTL and testbench

- Front-end controller that drives the datapath ALU.
- Accepts an operation request (main-decoder ALUOp plus R-type funct field, with two operands) over a valid/ready handshake.
- Decodes the request to the ALU's 4-bit op select, presents the operands to the ALU for one cycle, and captures the result.
- Returns the result, a zero flag and an error flag over a second valid/ready handshake with backpressure.
- Sits between the instruction decode stage and the combinational ALU.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_decode.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 118 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, R-type funct values, ALUOp encodings
// and the issue-controller state type.
package alu_pkg;

  localparam logic [3:0] OP_SUM = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1010;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } issue_state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALUOp/funct decoder producing the ALU select and an illegal flag.
// Illegal requests always map to OP_SUM so no undefined code ever leaves here.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] sel,
  output logic       illegal
);

  always_comb begin
    sel     = OP_SUM;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: sel = OP_SUM;
      ALUOP_SUB: sel = OP_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD, F_ADDU: sel = OP_SUM;
          F_SUB, F_SUBU: sel = OP_SUB;
          F_AND:         sel = OP_AND;
          F_OR:          sel = OP_OR;
          F_XOR:         sel = OP_XOR;
          F_NOR:         sel = OP_NOR;
          F_SLT:         sel = OP_SLT;
          default:       illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts an ALU request, drives the combinational ALU for
// one cycle, captures the result and hands it off with backpressure.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [N-1:0]     op_a_i,
  input  logic [N-1:0]     op_b_i,
  output logic [3:0]       alu_sel_o,
  output logic [N-1:0]     alu_a_o,
  output logic [N-1:0]     alu_b_o,
  input  logic [N-1:0]     alu_res_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     res_o,
  output logic             zero_o,
  output logic             err_o,
  output logic [CNT_W-1:0] op_count_o
);

  issue_state_t state_q, state_d;

  logic [3:0]       dec_sel;
  logic             dec_illegal;

  logic [3:0]       sel_p0;
  logic [N-1:0]     a_p0;
  logic [N-1:0]     b_p0;
  logic             ill_p0;

  logic [N-1:0]     res_p1;
  logic             zero_p1;
  logic             err_p1;
  logic [CNT_W-1:0] count_q;

  logic accept;
  logic handoff;
  logic drive_alu;

  alu_decode u_decode (
    .alu_op  (alu_op_i),
    .funct   (funct_i),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  assign accept    = (state_q == ST_IDLE) && in_valid_i;
  assign handoff   = (state_q == ST_DONE) && out_ready_i;
  assign drive_alu = (state_q == ST_EXEC) && !ill_p0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Stage p0: request capture (data only, consumed solely in EXEC)
  always_ff @(posedge clk_i) begin
    if (accept) begin
      sel_p0 <= dec_sel;
      a_p0   <= op_a_i;
      b_p0   <= op_b_i;
      ill_p0 <= dec_illegal;
    end
  end

  // Stage p1: result capture; reset because the result is visible after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      if (ill_p0) begin
        res_p1  <= '0;
        zero_p1 <= 1'b0;
        err_p1  <= 1'b1;
      end else begin
        res_p1  <= alu_res_i;
        zero_p1 <= (alu_res_i == '0);
        err_p1  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        count_q <= '0;
    else if (handoff) count_q <= count_q + 1'b1;
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign alu_sel_o   = drive_alu ? sel_p0 : OP_SUM;
  assign alu_a_o     = drive_alu ? a_p0   : '0;
  assign alu_b_o     = drive_alu ? b_p0   : '0;
  assign res_o       = res_p1;
  assign zero_o      = zero_p1;
  assign err_o       = err_p1;
  assign op_count_o  = count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized and directed bench for alu_issue_ctrl with a behavioural ALU stub
// and a table-level reference model of the decode/result rules.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int N     = 32;
  localparam int CNT_W = 6;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [1:0]       alu_op_i = '0;
  logic [5:0]       funct_i = '0;
  logic [N-1:0]     op_a_i = '0;
  logic [N-1:0]     op_b_i = '0;
  logic [3:0]       alu_sel_o;
  logic [N-1:0]     alu_a_o;
  logic [N-1:0]     alu_b_o;
  logic [N-1:0]     alu_res_i;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [N-1:0]     res_o;
  logic             zero_o;
  logic             err_o;
  logic [CNT_W-1:0] op_count_o;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  always #5 clk_i = ~clk_i;

  alu_issue_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .alu_op_i    (alu_op_i),
    .funct_i     (funct_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .alu_sel_o   (alu_sel_o),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_res_i   (alu_res_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .res_o       (res_o),
    .zero_o      (zero_o),
    .err_o       (err_o),
    .op_count_o  (op_count_o)
  );

  // Stand-in for the datapath ALU
  always_comb begin
    alu_res_i = '0;
    case (alu_sel_o)
      4'b0000: alu_res_i = alu_a_o + alu_b_o;
      4'b0010: alu_res_i = alu_a_o - alu_b_o;
      4'b0100: alu_res_i = alu_a_o & alu_b_o;
      4'b0101: alu_res_i = alu_a_o | alu_b_o;
      4'b0110: alu_res_i = alu_a_o ^ alu_b_o;
      4'b0111: alu_res_i = ~(alu_a_o | alu_b_o);
      4'b1010: alu_res_i = {31'd0, $signed(alu_a_o) < $signed(alu_b_o)};
      default: alu_res_i = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [3:0] sel, output logic [31:0] res,
                                output logic err);
    err = 1'b0;
    sel = 4'b0000;
    res = '0;
    if (op == 2'b00) begin
      sel = 4'b0000; res = a + b;
    end else if (op == 2'b01) begin
      sel = 4'b0010; res = a - b;
    end else if (op == 2'b11) begin
      err = 1'b1;
    end else begin
      case (f)
        6'h20, 6'h21: begin sel = 4'b0000; res = a + b; end
        6'h22, 6'h23: begin sel = 4'b0010; res = a - b; end
        6'h24: begin sel = 4'b0100; res = a & b; end
        6'h25: begin sel = 4'b0101; res = a | b; end
        6'h26: begin sel = 4'b0110; res = a ^ b; end
        6'h27: begin sel = 4'b0111; res = ~(a | b); end
        6'h2A: begin sel = 4'b1010; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        default: err = 1'b1;
      endcase
    end
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready_o, 1);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_res"}, res_o, 0);
    check({tag, "_zero"}, zero_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_count"}, op_count_o, 0);
    check({tag, "_alu_sel"}, alu_sel_o, 0);
    check({tag, "_alu_a"}, alu_a_o, 0);
    check({tag, "_alu_b"}, alu_b_o, 0);
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
    in_valid_i = 1'b1;
    alu_op_i   = op;
    funct_i    = f;
    op_a_i     = a;
    op_b_i     = b;
  endtask

  task automatic scramble_req(input logic valid);
    in_valid_i = valid;
    alu_op_i   = 2'($urandom);
    funct_i    = 6'($urandom);
    op_a_i     = $urandom;
    op_b_i     = $urandom;
  endtask

  // One full transaction: accept, EXEC, DONE with bp stall cycles, handoff
  task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input int bp);
    logic [3:0]  e_sel;
    logic [31:0] e_res;
    logic        e_err;
    model(op, f, a, b, e_sel, e_res, e_err);
    drive_req(op, f, a, b);
    out_ready_i = 1'b0;
    check({tag, "_ready_idle"}, in_ready_o, 1);
    tick();
    scramble_req(1'b0);
    check({tag, "_exec_sel"}, alu_sel_o, e_sel);
    check({tag, "_exec_a"}, alu_a_o, e_err ? 32'd0 : a);
    check({tag, "_exec_b"}, alu_b_o, e_err ? 32'd0 : b);
    check({tag, "_exec_ready"}, in_ready_o, 0);
    check({tag, "_exec_valid"}, out_valid_o, 0);
    tick();
    check({tag, "_done_valid"}, out_valid_o, 1);
    check({tag, "_res"}, res_o, e_res);
    check({tag, "_zero"}, zero_o, (!e_err && e_res == 0) ? 1 : 0);
    check({tag, "_err"}, err_o, e_err);
    check({tag, "_done_sel"}, alu_sel_o, 0);
    for (int i = 0; i < bp; i++) begin
      scramble_req(1'b1);
      tick();
      check({tag, "_bp_ready"}, in_ready_o, 0);
      check({tag, "_bp_valid"}, out_valid_o, 1);
      check({tag, "_bp_res"}, res_o, e_res);
      check({tag, "_bp_err"}, err_o, e_err);
      check({tag, "_bp_count"}, op_count_o, exp_count[CNT_W-1:0]);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    exp_count = (exp_count + 1) % (1 << CNT_W);
    check({tag, "_count"}, op_count_o, exp_count[CNT_W-1:0]);
    check({tag, "_post_valid"}, out_valid_o, 0);
    check({tag, "_post_ready"}, in_ready_o, 1);
    in_valid_i = 1'b0;
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [5:0]  r_f;
    logic [5:0]  legal_f [9];
    legal_f = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check_reset_state("reset");

    // Reset while in EXEC
    drive_req(2'b10, 6'h20, 32'd7, 32'd5);
    tick();
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_state("rst_exec");

    // Reset while in DONE with an unconsumed result
    drive_req(2'b00, 6'h00, 32'd100, 32'd23);
    tick();
    in_valid_i = 1'b0;
    tick();
    check("rst_done_pre_valid", out_valid_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_state("rst_done");

    do_op("add_funct", 2'b10, 6'h20, 32'd7, 32'd5, 0);
    do_op("sub_zero", 2'b01, 6'h00, 32'd9, 32'd9, 0);
    do_op("slt", 2'b10, 6'h2A, 32'd3, 32'd5, 0);
    do_op("and", 2'b10, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op("or", 2'b10, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op("xor", 2'b10, 6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op("nor", 2'b10, 6'h27, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op("slt_neg", 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("ill_funct", 2'b10, 6'h08, 32'd1234, 32'd99, 0);
    do_op("ill_op", 2'b11, 6'h20, 32'd1, 32'd2, 0);
    do_op("backpressure", 2'b00, 6'h00, 32'h8000_0000, 32'h8000_0000, 5);
    do_op("after_bp", 2'b10, 6'h22, 32'd10, 32'd3, 0);

    // Random traffic; long enough to wrap the counter several times
    for (int n = 0; n < 150; n++) begin
      r_op = 2'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : 3);
      r_f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 8)];
      do_op("rand", r_op, r_f, $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
            $urandom_range(0, 2));
    end

    // Top off so the next completion lands exactly on the wrap
    while (exp_count != (1 << CNT_W) - 1)
      do_op("fill", 2'b00, 6'h00, $urandom, $urandom, 0);
    check("pre_wrap_count", op_count_o, 6'h3F);
    do_op("wrap", 2'b01, 6'h00, 32'd5, 32'd6, 0);
    check("wrapped_count", op_count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
